// File: rtl/sync_debouncer.sv
// Synchronizes a raw asynchronous level, filters it until stable, and
// drives the clean level plus one-cycle rise/fall pulses.
module sync_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    output logic a,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   a_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    assign s    = sync[SYNC_STAGES-1];
    assign busy = (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            cnt  <= '0;
            a    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], a_raw};
            cnt  <= cnt_nxt;
            a    <= a_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end

    // A match with a abandons any candidate; a mismatch counts toward commit.
    always_comb begin
        cnt_nxt  = '0;
        a_nxt    = a;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (s != a) begin
            if (cnt == CNT_LAST) begin
                a_nxt    = s;
                rise_nxt = s;
                fall_nxt = ~s;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule
